// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host receiver (sync, glitch filter, parity/stop/timeout) emitting 8-bit scancodes with valid/err strobes
module ps2_rx_frame #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic clk_s1, clk_s2, dat_s1, dat_s2, filt, filt_d, par;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bitcnt;
  logic [7:0] sr;
  logic fall, expire, good, nxt_valid, nxt_err;
  assign fall = filt_d & ~filt;
  assign expire = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign good = dat_s2 & (^sr ^ par);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {clk_s1, clk_s2, dat_s1, dat_s2} <= '1;
      filt <= 1'b1;
      filt_d <= 1'b1;
      fcnt <= '0;
    end else begin
      {clk_s2, clk_s1} <= {clk_s1, ps2_clk};
      {dat_s2, dat_s1} <= {dat_s1, ps2_data};
      filt_d <= filt;
      if (clk_s2 == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= ~filt;
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  always_comb begin
    nxt = state;
    nxt_valid = 1'b0;
    nxt_err = 1'b0;
    if (expire) begin
      nxt = IDLE;
      nxt_err = 1'b1;
    end else if (fall)
      case (state)
        IDLE:    nxt = dat_s2 ? IDLE : DATA;
        DATA:    nxt = (bitcnt == 3'd7) ? PARITY : DATA;
        PARITY:  nxt = STOP;
        default: begin
          nxt = IDLE;
          nxt_valid = good;
          nxt_err = ~good;
        end
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rx_valid <= 1'b0;
      rx_err <= 1'b0;
      rx_data <= '0;
      tcnt <= '0;
      bitcnt <= '0;
      sr <= '0;
      par <= 1'b0;
    end else begin
      state <= nxt;
      rx_valid <= nxt_valid;
      rx_err <= nxt_err;
      if (nxt_valid) rx_data <= sr;
      tcnt <= (fall || state == IDLE) ? '0 : (tcnt == TW'(TIMEOUT_CYCLES - 1)) ? tcnt : tcnt + 1'b1;
      if (fall && !expire) begin
        if (state == IDLE) bitcnt <= '0;
        if (state == DATA) begin
          sr[bitcnt] <= dat_s2;
          bitcnt <= bitcnt + 1'b1;
        end
        if (state == PARITY) par <= dat_s2;
      end
    end
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: directed PS/2 frames against a latency-scheduled event model
module tb_ps2_rx_frame;
  localparam int FL = 8;
  localparam int T = 200;
  localparam int LAT = FL + 3;
  logic clk, rst_n, ps2_clk, ps2_data;
  logic [7:0] rx_data;
  logic rx_valid, rx_err, busy;
  int cyc = 0, n_cmp = 0, n_bad = 0, nv = 0, ne = 0, last_v = -1, last_e = -1;
  logic [7:0] valid_at [int];
  bit err_at [int];
  bit bon [int];
  bit boff [int];
  logic [7:0] exp_data = 8'h00;
  logic exp_busy = 1'b0, exp_v, exp_e;
  int ln;
  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (!rst_n) begin
      exp_data = 8'h00;
      exp_busy = 1'b0;
    end else begin
      if (valid_at.exists(cyc)) begin
        exp_v = 1'b1;
        exp_data = valid_at[cyc];
      end
      if (err_at.exists(cyc)) exp_e = 1'b1;
      if (bon.exists(cyc)) exp_busy = 1'b1;
      if (boff.exists(cyc)) exp_busy = 1'b0;
    end
    chk("rx_valid", 32'(rx_valid), 32'(exp_v));
    chk("rx_err", 32'(rx_err), 32'(exp_e));
    chk("rx_data", 32'(rx_data), 32'(exp_data));
    chk("busy", 32'(busy), 32'(exp_busy));
    if (rx_valid) begin
      nv++;
      last_v = cyc;
    end
    if (rx_err) begin
      ne++;
      last_e = cyc;
    end
  end
  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic par, input logic stp, input int nbits,
                      input int glitch_at, input bit abort_end, output int last_n);
    logic [10:0] b;
    int n;
    b = {stp, par, d, 1'b0};
    last_n = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      wait_cyc(10);
      ps2_clk = 1'b0;
      n = cyc;
      last_n = n;
      if (i == 0) bon[n + LAT] = 1'b1;
      if (i == nbits - 1) begin
        if (nbits == 11) begin
          boff[n + LAT] = 1'b1;
          if (stp && (($countones(d) + int'(par)) % 2 == 1)) valid_at[n + LAT] = d;
          else err_at[n + LAT] = 1'b1;
        end else if (!abort_end) begin
          err_at[n + LAT + T] = 1'b1;
          boff[n + LAT + T] = 1'b1;
        end
      end
      wait_cyc(30);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        wait_cyc(15);
        ps2_clk = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(10);
      end else wait_cyc(30);
    end
    ps2_data = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(20);
    send(8'h1C, 1'b1, 1'b1, 11, -1, 1'b0, ln);
    wait_cyc(20);
    chk("parity_err_count", 32'(ne), 32'd1);
    chk("parity_no_valid", 32'(nv), 32'd0);
    chk("parity_keeps_data", 32'(rx_data), 32'h00);
    send(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0, ln);
    wait_cyc(20);
    chk("good_1c_count", 32'(nv), 32'd1);
    chk("good_1c_data", 32'(rx_data), 32'h1C);
    chk("good_1c_latency", 32'(last_v), 32'(ln + 11));
    send(8'hF0, 1'b1, 1'b1, 11, -1, 1'b0, ln);
    send(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0, ln);
    wait_cyc(20);
    chk("b2b_count", 32'(nv), 32'd3);
    chk("b2b_data", 32'(rx_data), 32'h1C);
    chk("b2b_no_err", 32'(ne), 32'd1);
    send(8'hF0, 1'b1, 1'b1, 11, 4, 1'b0, ln);
    wait_cyc(20);
    chk("glitch_count", 32'(nv), 32'd4);
    chk("glitch_data", 32'(rx_data), 32'hF0);
    send(8'h1C, 1'b0, 1'b1, 6, -1, 1'b0, ln);
    wait_cyc(T);
    chk("timeout_err_count", 32'(ne), 32'd2);
    chk("timeout_err_cycle", 32'(last_e), 32'(ln + 11 + 200));
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_data", 32'(rx_data), 32'hF0);
    send(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0, ln);
    wait_cyc(20);
    chk("after_timeout_count", 32'(nv), 32'd5);
    chk("after_timeout_data", 32'(rx_data), 32'h1C);
    send(8'h1C, 1'b0, 1'b1, 5, -1, 1'b1, ln);
    rst_n = 1'b0;
    wait_cyc(3);
    chk("reset_data", 32'(rx_data), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cyc(20);
    send(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0, ln);
    wait_cyc(20);
    chk("after_reset_count", 32'(nv), 32'd6);
    chk("after_reset_err", 32'(ne), 32'd2);
    chk("after_reset_data", 32'(rx_data), 32'h1C);
    wait_cyc(T + 20);
    chk("final_err", 32'(ne), 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- Synchronous PS/2 device-to-host frame receiver in the system clock domain.
- Sits directly upstream of the keyboard scancode/key-event decoder. Turns the raw ps2_clk/ps2_data pins into validated 8-bit scancodes with a one-cycle strobe.
- Replaces the practice of clocking logic on the PS/2 clock pin. Adds synchronisation, glitch filtering, parity/stop checking and inter-bit timeout.

Parameters:
- FILTER_LEN, 8: consecutive identical clk samples required before the filtered ps2_clk level changes. Range 2..255.
- TIMEOUT_CYCLES, 50000: clk cycles with no filtered ps2_clk falling edge before an in-progress frame is aborted (1 ms at 50 MHz). Must be > FILTER_LEN.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous, idle high
- ps2_data  in  1  raw PS/2 data pin, asynchronous, idle high
- rx_data  out  8  last correctly received scancode, LSB = first data bit
- rx_valid  out  1  one-cycle pulse: rx_data just updated with a good frame
- rx_err  out  1  one-cycle pulse: frame dropped (start/parity/stop/timeout)
- busy  out  1  high while state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, bit counter=0, shift reg=0, rx_data=8'h00, rx_valid=0, rx_err=0, busy=0, filtered clk level=1, filter counter=0, timeout counter=0, both sync chains=1.
- Sync: ps2_clk and ps2_data each pass through a 2-FF synchroniser. Only synchronised values are used downstream.
- Filter on synced ps2_clk:
  - Counter increments while the sample differs from the filtered level; resets to 0 when they match.
  - On reaching FILTER_LEN-1 with a differing sample, the filtered level flips and the counter clears.
  - Pulses shorter than FILTER_LEN cycles never reach the FSM.
- fall = one-cycle strobe when filtered level goes 1->0. The data bit is the synced ps2_data value in the fall cycle.
- FSM (advances only on fall, except timeout):
  - IDLE: fall with data=0 -> DATA, bit counter=0. Fall with data=1 -> stay IDLE, no error (spurious edge).
  - DATA: shift reg[bitcnt] <= data, bitcnt++. On the 8th bit -> PARITY.
  - PARITY: store parity bit -> STOP.
  - STOP: always returns to IDLE. Good frame when stop bit=1 and ones(shift reg)+parity is odd:
    - Good: rx_data <= shift reg and rx_valid=1 for exactly the next clk cycle.
    - Otherwise: rx_err=1 for one cycle, rx_data unchanged.
- Latency: rx_valid/rx_err register in the cycle after the 11th fall strobe. Raw 11th falling edge to rx_valid = FILTER_LEN+3 cycles, +1 for synchroniser phase.
- Timeout:
  - Counter clears on every fall and in IDLE; otherwise increments, saturating.
  - Reaching TIMEOUT_CYCLES-1 while not IDLE: -> IDLE, rx_err pulse, partial data discarded.
  - A fall in the same cycle as expiry: the timeout wins and the edge is ignored.
- rx_valid and rx_err are never high in the same cycle.
- Back-to-back frames need no gap beyond the protocol's own stop bit: IDLE accepts a start bit on the next fall.
- Reset mid-frame: immediate return to reset values. A frame in progress is lost silently (no rx_err).
- No host-to-device transmit. Pins are input-only.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0 LSB first, parity 0, stop 1), 30 us bit period at 50 MHz -> single rx_valid pulse, rx_data=8'h1C, rx_err never high, busy high from start fall to stop fall.
- Back-to-back F0 then 1C (parity 1 then 0), 50 us apart -> two rx_valid pulses with rx_data 8'hF0 then 8'h1C, no rx_err.
- Frame 0x1C with parity bit=1 -> one rx_err pulse, no rx_valid, rx_data keeps previous value (8'h00 after reset).
- 5-cycle low glitch on ps2_clk mid-frame of 0xF0 with FILTER_LEN=8 -> glitch ignored, rx_data=8'hF0 valid once.
- Stop after 5 data bits, hold ps2_clk high -> rx_err pulse exactly TIMEOUT_CYCLES after the last fall, busy drops. A following full 0x1C frame then receives correctly.
- rst_n low for 3 cycles after 4th data bit, then full 0x1C frame -> no rx_err/rx_valid from the aborted frame, outputs 0 during reset, rx_data=8'h1C after the new frame.
